dsp_chain_fp16_feeder: RTL and testbench

- Operand transmitter for a cascaded chain of fp16 sum-of-products DSP stages, where each stage's chainout feeds the next stage's chainin.
- Accepts one beat per cycle over a valid/ready stream. A beat holds four fp16 operands per stage: top_a, top_b, bot_a, bot_b.
- Buffers beats in a small FIFO and issues each stage's operands skewed by stage index, so partial sums meet the cascade at the right cycle.
- Tracks vector boundaries and emits a done pulse and result-valid strobe aligned to the final stage's output.

---
 rtl/dsp_chain_pkg.sv | 13 +
 rtl/dsp_chain_fp16_feeder_if.sv | 23 ++
 rtl/dsp_chain_beat_fifo.sv | 36 +++
 rtl/dsp_chain_fp16_feeder.sv | 82 ++++++++
 tb/tb_dsp_chain_fp16_feeder.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/dsp_chain_pkg.sv
// dsp_chain_pkg: shared widths, beat field offsets, FSM states and drain-length helper
package dsp_chain_pkg;
  localparam int FP16_W = 16;
  localparam int BEAT_W = 64;
  localparam int TOP_A_OFS = 48;
  localparam int TOP_B_OFS = 32;
  localparam int BOT_A_OFS = 16;
  localparam int BOT_B_OFS = 0;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic int drain_cycles(int ns, int lat, int res);
    return (ns - 1) * lat + res;
  endfunction
endpackage

// File: rtl/dsp_chain_fp16_feeder_if.sv
// dsp_chain_fp16_feeder_if: beat stream in, skewed per-stage operands and result tags out
// slave: feeder side; master: producer/consumer side
interface dsp_chain_fp16_feeder_if
  import dsp_chain_pkg::*;
#(parameter int NUM_STAGES = 2);
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_STAGES*BEAT_W-1:0]   in_data;
  logic                           in_last;
  logic [NUM_STAGES*FP16_W-1:0]   top_a;
  logic [NUM_STAGES*FP16_W-1:0]   top_b;
  logic [NUM_STAGES*FP16_W-1:0]   bot_a;
  logic [NUM_STAGES*FP16_W-1:0]   bot_b;
  logic [NUM_STAGES-1:0]          stage_valid;
  logic                           result_valid;
  logic                           result_last;
  logic                           busy;
  logic                           done;
  modport slave (input in_valid, in_data, in_last,
                 output in_ready, top_a, top_b, bot_a, bot_b, stage_valid, result_valid, result_last, busy, done);
  modport master (output in_valid, in_data, in_last,
                  input in_ready, top_a, top_b, bot_a, bot_b, stage_valid, result_valid, result_last, busy, done);
endinterface

// File: rtl/dsp_chain_beat_fifo.sv
// dsp_chain_beat_fifo: synchronous FIFO with full/empty flags and simultaneous push/pop
// ports: clk, reset (async active-low), i_push/i_data in, i_pop/o_data out, o_full, o_empty
module dsp_chain_beat_fifo #(
  parameter int W     = 129,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp] <= i_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(i_push);
      r_rp  <= r_rp + AW'(i_pop);
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_data  = r_mem[r_rp];
endmodule

// File: rtl/dsp_chain_fp16_feeder.sv
// dsp_chain_fp16_feeder: buffers fp16 operand beats and issues them skewed per cascade stage
// ports: clk, reset (async active-low), bus (beat stream in; operands, stage_valid, result tags, busy, done out)
module dsp_chain_fp16_feeder
  import dsp_chain_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int STAGE_LAT  = 1,
  parameter int RES_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic                      clk,
  input logic                      reset,
  dsp_chain_fp16_feeder_if.slave   bus
);
  localparam int W  = NUM_STAGES * BEAT_W;
  localparam int D  = drain_cycles(NUM_STAGES, STAGE_LAT, RES_LAT);
  localparam int CW = $clog2(D + 2);
  state_t        r_state;
  state_t        w_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic [W:0]    w_q;
  assign w_pop        = r_state != DRAIN && !w_empty;
  // a pop frees a slot in the same cycle, so a full FIFO still accepts
  assign bus.in_ready = reset && (!w_full || w_pop);
  assign w_push       = bus.in_valid && bus.in_ready;
  dsp_chain_beat_fifo #(.W(W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({bus.in_last, bus.in_data}),
    .o_data  (w_q),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  // DRAIN holds D+1 cycles so done lines up with the last result and the next pop follows it
  always_comb begin
    w_nxt = r_state == DRAIN ? (r_cnt == '0 ? IDLE : DRAIN) : w_pop ? (w_q[W] ? DRAIN : RUN) : r_state;
    w_cnt = (r_state != DRAIN && w_nxt == DRAIN) ? CW'(D) : r_cnt - CW'(r_cnt != '0);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
    end
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_state == DRAIN && r_cnt == '0;
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int N = 1 + s * STAGE_LAT;
    logic [BEAT_W:0] r_dl [N];
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        for (int i = 0; i < N; i++) r_dl[i] <= '0;
      end else begin
        r_dl[0] <= w_pop ? {1'b1, w_q[s*BEAT_W +: BEAT_W]} : '0;
        for (int i = 1; i < N; i++) r_dl[i] <= r_dl[i-1];
      end
    assign bus.top_a[s*FP16_W +: FP16_W] = r_dl[N-1][TOP_A_OFS +: FP16_W];
    assign bus.top_b[s*FP16_W +: FP16_W] = r_dl[N-1][TOP_B_OFS +: FP16_W];
    assign bus.bot_a[s*FP16_W +: FP16_W] = r_dl[N-1][BOT_A_OFS +: FP16_W];
    assign bus.bot_b[s*FP16_W +: FP16_W] = r_dl[N-1][BOT_B_OFS +: FP16_W];
    assign bus.stage_valid[s]            = r_dl[N-1][BEAT_W];
  end
  logic [1:0] r_tag [D + 1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i <= D; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_pop ? {1'b1, w_q[W]} : 2'b00;
      for (int i = 1; i <= D; i++) r_tag[i] <= r_tag[i-1];
    end
  assign bus.result_valid = r_tag[D][1];
  assign bus.result_last  = r_tag[D][0];
endmodule

// File: tb/tb_dsp_chain_fp16_feeder.sv
// tb_dsp_chain_fp16_feeder: randomized stream into two feeder configs checked against a queue model
module tb_dsp_chain_fp16_feeder;
  localparam int MAXC  = 1500;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dsp_chain_fp16_feeder_if #(.NUM_STAGES(2)) ifa ();
  dsp_chain_fp16_feeder_if #(.NUM_STAGES(4)) ifb ();
  dsp_chain_fp16_feeder #(.NUM_STAGES(2), .STAGE_LAT(1), .RES_LAT(2), .FIFO_DEPTH(DEPTH)) u_a (
    .clk(clk), .reset(rst_n), .bus(ifa));
  dsp_chain_fp16_feeder #(.NUM_STAGES(4), .STAGE_LAT(2), .RES_LAT(2), .FIFO_DEPTH(DEPTH)) u_b (
    .clk(clk), .reset(rst_n), .bus(ifb));
  int tests = 0;
  int fails = 0;
  int ns [2] = '{2, 4};
  int lat [2] = '{1, 2};
  int dd [2] = '{3, 8};
  bit [257:0] hist [2][MAXC];
  logic [256:0] qa [$];
  logic [256:0] qb [$];
  int blocked [2] = '{0, 0};
  bit in_vec [2] = '{0, 0};
  int cyc = 0;
  bit in_rst = 1'b1;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int qsize(int k);
    return k == 0 ? qa.size() : qb.size();
  endfunction
  function automatic logic [63:0] exp_field(int k, int off);
    logic [63:0] r = '0;
    for (int s = 0; s < ns[k]; s++) begin
      int i = cyc - 1 - s * lat[k];
      if (i >= 0 && hist[k][i][257]) r[s*16 +: 16] = hist[k][i][s*64 + off +: 16];
    end
    return r;
  endfunction
  function automatic logic [3:0] exp_sv(int k);
    logic [3:0] r = '0;
    for (int s = 0; s < ns[k]; s++) begin
      int i = cyc - 1 - s * lat[k];
      if (i >= 0) r[s] = hist[k][i][257];
    end
    return r;
  endfunction
  task automatic check_dut(int k, logic rdy, logic [63:0] ta, logic [63:0] tb, logic [63:0] ba,
                           logic [63:0] bb, logic [3:0] sv, logic rv, logic rl, logic bs, logic dn);
    string p = $sformatf("u%0d c%0d ", k, cyc);
    int ri = cyc - 1 - dd[k];
    logic pop = !in_rst && qsize(k) > 0 && cyc >= blocked[k];
    logic erv = ri >= 0 && hist[k][ri][257];
    logic erl = erv && hist[k][ri][256];
    chk({p, "in_ready"}, rdy, !in_rst && (qsize(k) < DEPTH || pop));
    chk({p, "top_a"}, ta, exp_field(k, 48));
    chk({p, "top_b"}, tb, exp_field(k, 32));
    chk({p, "bot_a"}, ba, exp_field(k, 16));
    chk({p, "bot_b"}, bb, exp_field(k, 0));
    chk({p, "stage_valid"}, sv, exp_sv(k));
    chk({p, "result_valid"}, rv, erv);
    chk({p, "result_last"}, rl, erl);
    chk({p, "done"}, dn, erl);
    chk({p, "busy"}, bs, in_vec[k] || cyc < blocked[k]);
  endtask
  task automatic step(int k, logic v, logic l, logic [255:0] d);
    logic [256:0] b;
    bit pop = qsize(k) > 0 && cyc >= blocked[k];
    bit rdy = qsize(k) < DEPTH || pop;
    hist[k][cyc] = '0;
    if (pop) begin
      b = k == 0 ? qa.pop_front() : qb.pop_front();
      hist[k][cyc] = {1'b1, b};
      if (b[256]) begin
        blocked[k] = cyc + dd[k] + 2;
        in_vec[k] = 1'b0;
      end else in_vec[k] = 1'b1;
    end
    if (v && rdy) begin
      if (k == 0) qa.push_back({l, d});
      else qb.push_back({l, d});
    end
  endtask
  task automatic tick(logic v, logic l, logic [255:0] d, bit rst);
    @(posedge clk);
    #1;
    if (rst && !in_rst) begin
      qa.delete();
      qb.delete();
      blocked = '{0, 0};
      in_vec = '{0, 0};
      for (int k = 0; k < 2; k++) for (int i = 0; i < MAXC; i++) hist[k][i] = '0;
    end
    rst_n = !rst;
    in_rst = rst;
    ifa.in_valid = v;
    ifa.in_last = l;
    ifa.in_data = d[127:0];
    ifb.in_valid = v;
    ifb.in_last = l;
    ifb.in_data = d;
    @(negedge clk);
    check_dut(0, ifa.in_ready, 64'(ifa.top_a), 64'(ifa.top_b), 64'(ifa.bot_a), 64'(ifa.bot_b),
              4'(ifa.stage_valid), ifa.result_valid, ifa.result_last, ifa.busy, ifa.done);
    check_dut(1, ifb.in_ready, ifb.top_a, ifb.top_b, ifb.bot_a, ifb.bot_b,
              ifb.stage_valid, ifb.result_valid, ifb.result_last, ifb.busy, ifb.done);
    if (!in_rst) begin
      step(0, v, l, d);
      step(1, v, l, d);
    end
    cyc++;
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 1'b0);
  endtask
  task automatic rnd(int vp, int lp, int n);
    for (int i = 0; i < n; i++) begin
      logic [255:0] d;
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom();
      tick($urandom_range(99) < vp, $urandom_range(99) < lp, d, 1'b0);
    end
  endtask
  initial begin
    logic [255:0] ones;
    logic [255:0] pat;
    logic [4:0] gap;
    ones = {16{16'h3C00}};
    pat = ones;
    pat[64 + 48 +: 16] = 16'h4000;
    gap = 5'b11001;
    ifa.in_valid = 1'b0;
    ifa.in_last = 1'b0;
    ifa.in_data = '0;
    ifb.in_valid = 1'b0;
    ifb.in_last = 1'b0;
    ifb.in_data = '0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b1, 1'b1, ones, 1'b0);
    idle(14);
    for (int i = 0; i < 8; i++) tick(1'b1, i == 7, pat, 1'b0);
    idle(20);
    for (int i = 0; i < 5; i++) tick(gap[i], i == 4, ones ^ 256'(i), 1'b0);
    idle(20);
    tick(1'b1, 1'b1, ones, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, i == 4, pat ^ 256'(i), 1'b0);
    idle(30);
    rnd(100, 15, 150);
    rnd(30, 30, 150);
    rnd(70, 10, 150);
    idle(20);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, pat ^ 256'(i), 1'b0);
    tick(1'b1, 1'b1, pat, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b1, 1'b1, ones, 1'b0);
    idle(20);
    rnd(80, 20, 200);
    idle(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
